// File: rtl/register_file_mp.sv
// Multi-read-port register file with x0 hardwired to zero and a power-on / on-demand clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module register_file_mp #(
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_REGS     = 32,
   parameter int NUM_RD_PORTS = 2,
   localparam int AW          = $clog2(NUM_REGS)
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               we_i,
   input  logic [AW-1:0]                      rd_addr_i,
   input  logic [DATA_WIDTH-1:0]              rd_i,
   input  logic [NUM_RD_PORTS*AW-1:0]         rs_addr_i,
   output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rs_o,
   input  logic                               clear_req_i,
   output logic                               ready_o
);

   // state | meaning
   // CLEAR | sweeping registers 1..NUM_REGS-1 to zero; reads return 0, writes dropped
   // READY | normal operation; writes accepted, stored data returned
   typedef enum logic {
      S_CLEAR = 1'b0,
      S_READY = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [AW-1:0]         clr_idx_q, clr_idx_d;
   logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

   logic                  wr_en;
   logic [AW-1:0]         wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_CLEAR;
         clr_idx_q <= AW'(1);
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      wr_en     = 1'b0;
      wr_addr   = rd_addr_i;
      wr_data   = rd_i;
      case (state_q)
         S_CLEAR: begin
            wr_en     = 1'b1;
            wr_addr   = clr_idx_q;
            wr_data   = '0;
            clr_idx_d = clr_idx_q + AW'(1);
            if (clr_idx_q == AW'(NUM_REGS - 1)) begin
               state_d   = S_READY;
               clr_idx_d = AW'(1);
            end
         end
         S_READY: begin
            clr_idx_d = AW'(1);
            if (clear_req_i) begin
               state_d = S_CLEAR;
            end else if (we_i && (rd_addr_i != '0)) begin
               wr_en = 1'b1;
            end
         end
         default: begin
            state_d   = S_CLEAR;
            clr_idx_d = AW'(1);
         end
      endcase
      // the array has no reset, so block any write racing an async reset
      if (rst_i) wr_en = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   always_comb begin
      logic [AW-1:0] raddr;
      rs_o  = '0;
      raddr = '0;
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
         raddr = rs_addr_i[p*AW +: AW];
         if ((state_q == S_READY) && (raddr != '0)) begin
`ifdef REGFILE_BYPASS_EN
            if (we_i && (raddr == rd_addr_i))
               rs_o[p*DATA_WIDTH +: DATA_WIDTH] = rd_i;
            else
               rs_o[p*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr];
`else
            rs_o[p*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr];
`endif
         end
      end
   end

   assign ready_o = (state_q == S_READY);

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, register width in bits.
REQ-002 The block SHALL have parameter NUM_REGS, default 32, register count, a power of two and at least 4; AW = $clog2(NUM_REGS).
REQ-003 The block SHALL have parameter NUM_RD_PORTS, default 2, number of independent read ports, range 1..4.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port we_i, input, 1 bit: write enable.
REQ-007 The block SHALL have port rd_addr_i, input, AW bits: write address.
REQ-008 The block SHALL have port rd_i, input, DATA_WIDTH bits: write data.
REQ-009 The block SHALL have port rs_addr_i, input, NUM_RD_PORTS*AW bits: read addresses; port p uses slice [p*AW +: AW].
REQ-010 The block SHALL have port rs_o, output, NUM_RD_PORTS*DATA_WIDTH bits: read data; port p drives slice [p*DATA_WIDTH +: DATA_WIDTH].
REQ-011 The block SHALL have port clear_req_i, input, 1 bit: request a full clear sweep.
REQ-012 The block SHALL have port ready_o, output, 1 bit: high when the file accepts writes and returns stored data.

Function
REQ-013 Register 0 SHALL always read 0, and writes to address 0 SHALL be discarded.
REQ-014 Reads SHALL be combinational: rs_o slice p equals the content of the register at rs_addr_i slice p, in the same cycle.
REQ-015 A write SHALL take effect at the rising edge where we_i=1 and state is READY, and SHALL be visible on reads after that edge.
REQ-016 The FSM SHALL have two states: CLEAR and READY.
REQ-017 In CLEAR, a counter clr_idx SHALL zero register clr_idx at each rising edge and then increment.
REQ-018 The FSM SHALL move CLEAR->READY at the edge that clears register NUM_REGS-1, so a sweep lasts NUM_REGS-1 edges (31 by default).
REQ-019 In CLEAR, ready_o SHALL be 0, all rs_o slices SHALL read 0, and we_i SHALL be ignored (the write is lost, not queued).
REQ-020 In READY, clear_req_i=1 at an edge SHALL move the FSM to CLEAR with clr_idx=1.
REQ-021 If clear_req_i and we_i are both 1 at the same READY edge, the clear SHALL win and the write SHALL be discarded.
REQ-022 clear_req_i SHALL be ignored while in CLEAR; the sweep does not restart.
REQ-023 ready_o SHALL be 1 exactly when the state is READY (registered, no combinational path from inputs).

Reset
REQ-024 While rst_i=1, the state SHALL be CLEAR, clr_idx SHALL be 1, ready_o SHALL be 0 and rs_o SHALL be all zeros.
REQ-025 Register array contents SHALL NOT be reset directly; they SHALL be zeroed only by the sweep.
REQ-026 rst_i asserted mid-sweep or mid-write SHALL restart the sweep from register 1 once rst_i deasserts.

Configuration
REQ-027 With macro REGFILE_BYPASS_EN defined, in READY a read whose address equals rd_addr_i (non-zero) while we_i=1 SHALL return rd_i combinationally in that cycle (write-first forwarding).
REQ-028 Without REGFILE_BYPASS_EN, the same read SHALL return the old stored value until after the write edge.

Verification
REQ-029 The bench SHALL cover reset then idle, defaults: rs_o=0 and ready_o=0 for 30 edges; ready_o=1 after edge 31.
REQ-030 The bench SHALL cover a write of 0x0000_0001 to x1, then reading x1 on port 0 and x2 on port 1: port 0 returns 0x0000_0001, port 1 returns 0x0000_0000.
REQ-031 The bench SHALL cover a write of 0xFFFF_FFFF to x31 followed by a write of 0xDEAD_BEEF to x0: x31 reads 0xFFFF_FFFF and x0 reads 0.
REQ-032 The bench SHALL cover clear_req_i pulsed together with a we_i write of 0x1234_5678 to x5: the write is dropped, ready_o falls for 31 edges, and x5 and x31 read 0 afterwards.
REQ-033 The bench SHALL cover rst_i asserted at sweep edge 10 and then released: the sweep restarts and ready_o rises 31 edges after release.
REQ-034 The bench SHALL cover, with REGFILE_BYPASS_EN, we_i=1, rd_addr_i=7, rd_i=0xA5A5_A5A5 and rs_addr port 0 = 7: same-cycle read returns 0xA5A5_A5A5; without the macro it returns the prior value 0.
